// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: 5..8 data bits, none/odd/even parity, 1 or 2 stop bits, optional input FIFO.
// Optional line-break control is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_frame #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_EA   = 0
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       o_tready,
    input  logic       i_tvalid,
    input  logic [7:0] i_tdata,
    input  logic       i_tkeep,
`ifdef UART_TX_BREAK_EN
    input  logic       i_break,
`endif
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [2:0]    BIT_MAX  = 3'(DATA_BITS - 1);
    localparam logic          STOP_MAX = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic       brk;
    logic       adv;
    logic       ld_pt;
    logic       take;
    logic       src_vld;
    logic       src_keep;
    logic [7:0] src_data;
    logic       fifo_ne;
    logic       unused_bits;

`ifdef UART_TX_BREAK_EN
    assign brk = i_break;
`else
    assign brk = 1'b0;
`endif

    assign adv   = (cnt_q == CNT_MAX);
    // Load point: idle, or the very last cycle of the final stop bit so frames abut.
    assign ld_pt = ~brk & ((state_q == S_IDLE) |
                           ((state_q == S_STOP) & adv & (stop_q == STOP_MAX)));
    assign take  = ld_pt & src_vld;

    // Upper data bits beyond DATA_BITS are deliberately dropped.
    assign unused_bits = &{1'b0, src_data};

    generate
        if (FIFO_EA != 0) begin : g_fifo
            localparam int EA = (FIFO_EA < 2) ? 2 : FIFO_EA;

            logic [8:0]  mem_q [2**EA];
            logic [EA:0] wp_q, rp_q;
            logic        empty, full, push;

            assign empty    = (wp_q == rp_q);
            assign full     = (wp_q[EA] != rp_q[EA]) && (wp_q[EA-1:0] == rp_q[EA-1:0]);
            assign o_tready = rstn & ~full & ~brk;
            assign push     = i_tvalid & o_tready;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    wp_q <= '0;
                    rp_q <= '0;
                end else begin
                    if (push) wp_q <= wp_q + 1'b1;
                    if (take) rp_q <= rp_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (push) mem_q[wp_q[EA-1:0]] <= {i_tkeep, i_tdata};
            end

            assign src_vld               = ~empty;
            assign {src_keep, src_data}  = mem_q[rp_q[EA-1:0]];
            assign fifo_ne               = ~empty;
        end else begin : g_nofifo
            assign o_tready = rstn & ld_pt;
            assign src_vld  = i_tvalid;
            assign src_keep = i_tkeep;
            assign src_data = i_tdata;
            assign fifo_ne  = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        par_d   = par_q;

        if (state_q != S_IDLE) cnt_d = adv ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: ;
            S_START: begin
                if (adv) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (adv) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (adv) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (adv) begin
                    if (stop_q == STOP_MAX) state_d = S_IDLE;
                    else                    stop_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A discarded word (keep=0) is consumed here without ever leaving IDLE.
        if (take) begin
            cnt_d = '0;
            if (src_keep) begin
                state_d = S_START;
                sh_d    = src_data[DATA_BITS-1:0];
                par_d   = (^src_data[DATA_BITS-1:0]) ^ (PARITY == 1);
            end else begin
                state_d = S_IDLE;
            end
        end

        case (state_q)
            S_IDLE:  tx_d = ~brk;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_q[0];
            S_PAR:   tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
        par_q <= par_d;
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != S_IDLE) | fifo_ne | brk;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7E2, 8N1 with FIFO) checked against a cycle-level line model.
module tb_uart_tx_frame;

    localparam int DIV = 10;
    localparam int NC  = 16384;
    localparam int DB  [3] = '{8, 7, 8};
    localparam int PAR [3] = '{0, 2, 0};
    localparam int STP [3] = '{1, 2, 1};

    typedef struct {
        int          d;
        logic [7:0]  w;
        int          nb;
        logic [11:0] bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tvalid [3];
    logic [7:0] tdata  [3];
    logic       tkeep  [3];
    logic       tready [3];
    logic       tx     [3];
    logic       busy   [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    int         next_load [3];
    bit         exp_line  [3][NC];
    bit         exp_busy  [3][NC];
    logic [8:0] fq [$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_EA(0)) u0 (
        .clk(clk), .rstn(rstn), .o_tready(tready[0]), .i_tvalid(tvalid[0]),
        .i_tdata(tdata[0]), .i_tkeep(tkeep[0]),
`ifdef UART_TX_BREAK_EN
        .i_break(1'b0),
`endif
        .o_uart_tx(tx[0]), .o_busy(busy[0]));

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_EA(0)) u1 (
        .clk(clk), .rstn(rstn), .o_tready(tready[1]), .i_tvalid(tvalid[1]),
        .i_tdata(tdata[1]), .i_tkeep(tkeep[1]),
`ifdef UART_TX_BREAK_EN
        .i_break(1'b0),
`endif
        .o_uart_tx(tx[1]), .o_busy(busy[1]));

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_EA(2)) u2 (
        .clk(clk), .rstn(rstn), .o_tready(tready[2]), .i_tvalid(tvalid[2]),
        .i_tdata(tdata[2]), .i_tkeep(tkeep[2]),
`ifdef UART_TX_BREAK_EN
        .i_break(1'b0),
`endif
        .o_uart_tx(tx[2]), .o_busy(busy[2]));

    function automatic int flen(input int d);
        return (1 + DB[d] + ((PAR[d] != 0) ? 1 : 0) + STP[d]) * DIV;
    endfunction

    // Line value of frame bit i: start, data LSB first, optional parity, stop bits.
    function automatic logic fbit(input int d, input logic [7:0] w, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i <= DB[d]) return w[i-1];
        if (PAR[d] != 0 && i == DB[d] + 1) begin
            ones = 0;
            for (int j = 0; j < DB[d]; j++) ones += int'(w[j]);
            return logic'(((ones % 2) == 1) ^ (PAR[d] == 1));
        end
        return 1'b1;
    endfunction

    task automatic schedule(input int d, input int k, input logic [7:0] w, input logic keep);
        int fl;
        fl = flen(d);
        if (keep) begin
            for (int s = k; s < k + fl && s + 1 < NC; s++) begin
                exp_busy[d][s]   = 1'b1;
                exp_line[d][s+1] = fbit(d, w, (s - k) / DIV);
            end
            next_load[d] = k + fl;
        end else begin
            next_load[d] = k + 1;
        end
    endtask

    task automatic chk_bit(input string nm, input int d, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %b, expected %b", nm, d, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: one step per clock edge, acceptance decided by the model's own ready rule.
    initial begin
        logic [8:0] w;
        bit room;
        for (int d = 0; d < 3; d++) begin
            next_load[d] = 0;
            for (int s = 0; s < NC; s++) begin
                exp_line[d][s] = 1'b1;
                exp_busy[d][s] = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) begin
                for (int d = 0; d < 3; d++) begin
                    for (int s = cyc; s < cyc + 200 && s < NC; s++) begin
                        exp_line[d][s] = 1'b1;
                        exp_busy[d][s] = 1'b0;
                    end
                    next_load[d] = cyc + 1;
                end
                fq.delete();
            end else begin
                for (int d = 0; d < 2; d++)
                    if (tvalid[d] && cyc >= next_load[d]) schedule(d, cyc, tdata[d], tkeep[d]);
                room = (fq.size() < 4);
                if (cyc >= next_load[2] && fq.size() > 0) begin
                    w = fq.pop_front();
                    schedule(2, cyc, w[7:0], w[8]);
                end
                if (tvalid[2] && room) fq.push_back({tkeep[2], tdata[2]});
            end
        end
    end

    initial begin
        logic exp_tr;
        forever begin
            @(negedge clk);
            if (chk_en && cyc < NC) begin
                for (int d = 0; d < 3; d++) begin
                    exp_tr = (d == 2) ? logic'(fq.size() < 4) : logic'(cyc + 1 >= next_load[d]);
                    chk_bit("line", d, tx[d], exp_line[d][cyc]);
                    chk_bit("tready", d, tready[d], rstn & exp_tr);
                    chk_bit("busy", d, busy[d], exp_busy[d][cyc] | (d == 2 && fq.size() > 0));
                end
            end
        end
    end

    initial begin
        #150000;
        $display("FAIL watchdog: reached cycle %0d, required completion well before it", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] w, input logic k, output int kedge);
        bit hs;
        tvalid[d] = 1'b1;
        tdata[d]  = w;
        tkeep[d]  = k;
        kedge     = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            hs = tready[d];
            if (hs) kedge = cyc + 1;
            step();
            if (hs) break;
        end
        if (kedge < 0) chk_int("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        tvalid[d] = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        if (!ok) chk_int("idle_timeout", 0, 1);
    endtask

    task automatic at_sample(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic rand_stream(input int d);
        int kk;
        for (int i = 0; i < 25; i++) begin
            send(d, 8'($urandom), logic'($urandom_range(3) != 0), kk);
            if ($urandom_range(2) == 0) begin
                tvalid[d] = 1'b0;
                repeat ($urandom_range(15)) step();
            end
        end
        tvalid[d] = 1'b0;
    endtask

    initial begin
        vec_t tbl [7];
        int k, k1, k2, kc, lat;

        tbl[0] = '{0, 8'hA5, 10, 12'h34A};
        tbl[1] = '{0, 8'h55, 10, 12'h2AA};
        tbl[2] = '{0, 8'hAA, 10, 12'h354};
        tbl[3] = '{1, 8'h83, 11, 12'h606};
        tbl[4] = '{1, 8'hFF, 11, 12'h7FE};
        tbl[5] = '{1, 8'h80, 11, 12'h600};
        tbl[6] = '{2, 8'h3C, 10, 12'h278};

        rstn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            tvalid[d] = 1'b0;
            tdata[d]  = 8'h00;
            tkeep[d]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn   = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wait_idle(tbl[i].d);
            send(tbl[i].d, tbl[i].w, 1'b1, k);
            tvalid[tbl[i].d] = 1'b0;
            lat = (tbl[i].d == 2) ? 2 : 1;
            at_sample(k + lat - 1);
            chk_bit("tbl_prestart", tbl[i].d, tx[tbl[i].d], 1'b1);
            for (int b = 0; b < tbl[i].nb; b++) begin
                at_sample(k + lat + b * DIV + DIV / 2);
                chk_bit("tbl_bit", tbl[i].d, tx[tbl[i].d], tbl[i].bits[b]);
            end
            at_sample(k + lat + tbl[i].nb * DIV);
            chk_bit("tbl_after", tbl[i].d, tx[tbl[i].d], 1'b1);
        end

        // Back-to-back frames with tvalid held high.
        wait_idle(0);
        send(0, 8'h55, 1'b1, k1);
        send(0, 8'hAA, 1'b1, k2);
        tvalid[0] = 1'b0;
        chk_int("b2b_spacing", k2 - k1, 100);
        at_sample(k2 + 1);
        chk_bit("b2b_second_start", 0, tx[0], 1'b0);

        // Discarded word between two kept words.
        wait_idle(0);
        send(0, 8'h11, 1'b1, k1);
        send(0, 8'h22, 1'b0, k2);
        send(0, 8'h33, 1'b1, kc);
        tvalid[0] = 1'b0;
        chk_int("keep0_at_load_point", k2 - k1, 100);
        chk_int("keep0_cost", kc - k2, 1);

        // FIFO burst while the engine is busy.
        wait_idle(2);
        send(2, 8'hC1, 1'b1, k1);
        for (int i = 0; i < 5; i++) send(2, 8'(8'hD0 + i), 1'b1, k2);
        tvalid[2] = 1'b0;
        chk_int("fifo_fifth_wait", k2 - k1, 102);
        wait_idle(2);

        // Reset mid-frame, with words still queued in the FIFO.
        wait_idle(0);
        send(2, 8'h5A, 1'b1, k);
        send(2, 8'h6B, 1'b1, k);
        send(2, 8'h7C, 1'b0, k);
        tvalid[2] = 1'b0;
        send(0, 8'hC3, 1'b1, k);
        tvalid[0] = 1'b0;
        at_sample(k + 34);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk_bit("rst_line", 0, tx[0], 1'b1);
        chk_bit("rst_busy", 0, busy[0], 1'b0);
        chk_bit("rst_fifo_busy", 2, busy[2], 1'b0);
        chk_bit("rst_fifo_ready", 2, tready[2], 1'b1);
        step();
        send(0, 8'hE7, 1'b1, k);
        tvalid[0] = 1'b0;
        wait_idle(0);

        fork
            rand_stream(0);
            rand_stream(1);
            rand_stream(2);
        join
        for (int d = 0; d < 3; d++) wait_idle(d);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 TX. Adds configurable clock/baud, data bits (5-8), parity (none/odd/even), 1 or 2 stop bits, an optional input FIFO, tkeep-based word drop, and gap-free back-to-back frames. Sits between an AXI-Stream-style byte source (UART-to-APB bridge response path) and the TX pin.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_EA, 0, 0 = no FIFO; otherwise depth = 2^max(FIFO_EA,2)

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock; reset is synchronous and active-low
o_tready  out  1  input word accepted when i_tvalid & o_tready at posedge clk
i_tvalid  in  1  input word valid
i_tdata  in  8  input word; bits [DATA_BITS-1:0] sent, upper bits ignored
i_tkeep  in  1  1 = transmit word; 0 = consume and discard, no line activity
o_uart_tx  out  1  serial line, idle high, registered
o_busy  out  1  engine not IDLE or FIFO non-empty

Behaviour:
- Reset (rstn low at posedge): o_uart_tx=1, o_busy=0, o_tready=0 during reset cycle, FIFO emptied, state IDLE, counters 0. Reset mid-frame aborts the frame; line is high from the next edge.
- Frame: start(0), data LSB first, parity bit if PARITY!=0 (odd: XOR of data bits inverted; even: XOR of data bits), STOP_BITS stop bits (1). Each bit exactly DIV cycles. Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV cycles.
- States: IDLE -> START -> DATA -> (PARITY if enabled) -> STOP -> IDLE or START. Baud counter 0..DIV-1; bit advances when counter = DIV-1. Bit index 0..DATA_BITS-1 in DATA; stop index 0..STOP_BITS-1 in STOP.
- Load point: engine takes a word in IDLE, or in the final cycle of the last stop bit (counter = DIV-1). Taken word is latched into an internal shift/hold register; engine never reads source data after the load edge.
- No FIFO: o_tready = engine at load point (combinational from state/counter, not from i_tvalid). Handshake at edge N with i_tkeep=1 -> o_uart_tx low from edge N+1. Back-to-back words: no idle cycles between stop and next start.
- With FIFO: o_tready = FIFO not full (independent of engine). Push at edge N into empty FIFO with engine idle -> engine loads at edge N+1 -> o_uart_tx low from edge N+2. Full FIFO: o_tready=0, pop in same cycle does not enable push that cycle. Pointers are EA+1 bits, wrap naturally; full = MSB differs, rest equal.
- i_tkeep=0: word consumed (handshake or FIFO pop) in one cycle, engine stays IDLE/returns to IDLE, line remains high.
- o_busy registered-equivalent: high from load edge through last stop-bit cycle, or while FIFO non-empty.
- Unused i_tdata bits never influence parity or line.

Optional Feature:
UART_TX_BREAK_EN: adds input i_break (1 bit). When defined: i_break high while engine IDLE forces o_uart_tx=0 from next edge, holds o_tready=0 and o_busy=1; on deassert line returns high next edge, loading resumes. i_break asserted mid-frame is ignored until frame ends (frame completes normally, then break applies). When undefined: no i_break port, no break logic.

Test Plan:
CLK_FREQ=1000000, BAUD_RATE=100000 (DIV=10), 8N1, no FIFO; send 0xA5 -> line low 10 cycles from edge after handshake, then 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles; total 100 cycles.
Same config, tvalid held high with 0x55 then 0xAA -> second start bit begins exactly 100 cycles after first, zero idle cycles; tready pulses once per frame.
DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x83 -> data 1,1,0,0,0,0,0 then parity 0, two stop bits; frame 110 cycles; bit 7 ignored.
FIFO_EA=2, burst 5 words with engine busy -> 4 accepted, tready low on 5th until first pop; all 4 frames emitted gap-free in order.
i_tkeep=0 word between two keep=1 words -> only two frames on line, discarded word costs no line time.
Assert rstn low at cycle 35 of a frame -> o_uart_tx=1 next edge, o_busy=0, FIFO empty; next word after reset transmits correctly.
